// File: rtl/rs_drive_pkg.sv
// Shared definitions for the gated RS latch drive controller.
//   - FSM state encoding (also exported on the debug state port)
//   - default debounce / enable-pulse lengths
//   - widths of the debounce and enable counters
package rs_drive_pkg;

  localparam int DEB_CYCLES_DEF = 4;  // legal 1..255
  localparam int EN_CYCLES_DEF  = 2;  // legal 1..15

  localparam int DEB_CNT_W = 8;
  localparam int EN_CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ENABLE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_CHECK  = 3'd4
  } state_t;

endpackage

// File: rtl/rs_drive_ctrl_btn_debounce.sv
// btn_debounce: conditions one raw push-button.
//   clk  : clock
//   rst  : synchronous active-high reset
//   btn  : raw asynchronous, bouncing button input
//   rise : registered one-cycle pulse in the cycle the debounced level
//          becomes 1 (a falling debounced edge produces nothing)
// The button goes through a 2-flop synchronizer; the debounced level only
// follows the synchronized value after DEB_CYCLES consecutive samples that
// all differ from the current debounced level.
module btn_debounce
  import rs_drive_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEB_CYCLES - 1);

  logic                 sync1;
  logic                 sync2;
  logic                 level;
  logic [DEB_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      // The level is a single bit, so "differs from level" already implies
      // the samples in the run are all equal to each other.
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
          rise  <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/rs_drive_ctrl.sv
// rs_drive_ctrl: drives S/R/E of a gated RS latch from two push-buttons
// and verifies the result through the latch Q readback.
//   clk, rst        : clock, synchronous active-high reset
//   set_btn         : raw set button      -> write 1 into the latch
//   reset_btn       : raw reset button    -> write 0 into the latch
//   latch_q         : latch Q readback, checked once per write
//   s_out/r_out     : data drive, never both 1
//   e_out           : gate drive, EN_CYCLES clocks wide
//   busy            : write sequence in progress (state != IDLE)
//   conflict        : pulse, set and reset requested in the same cycle
//   drop            : pulse, single request discarded because busy
//   err             : sticky readback failure, cleared only by rst
//   state_dbg       : current FSM state
// Requests are one-cycle pulses with no back-pressure: a request is either
// accepted in IDLE or discarded (drop/conflict); nothing is ever queued.
// Write sequence: SETUP(1) -> ENABLE(EN_CYCLES) -> HOLD(1) -> CHECK(1).
// All outputs are registered and updated together with the state.
module rs_drive_ctrl
  import rs_drive_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int EN_CYCLES  = EN_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_btn,
  input  logic       reset_btn,
  input  logic       latch_q,
  output logic       s_out,
  output logic       r_out,
  output logic       e_out,
  output logic       busy,
  output logic       conflict,
  output logic       drop,
  output logic       err,
  output logic [2:0] state_dbg
);

  localparam logic [EN_CNT_W-1:0] EN_LAST = EN_CNT_W'(EN_CYCLES - 1);

  logic                set_req;
  logic                reset_req;
  logic                single_req;
  logic                pair_req;
  state_t              state;
  logic                tgt;
  logic [EN_CNT_W-1:0] en_cnt;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_set_deb (
    .clk  (clk),
    .rst  (rst),
    .btn  (set_btn),
    .rise (set_req)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_reset_deb (
    .clk  (clk),
    .rst  (rst),
    .btn  (reset_btn),
    .rise (reset_req)
  );

  assign single_req = set_req ^ reset_req;
  assign pair_req   = set_req & reset_req;
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tgt      <= 1'b0;
      en_cnt   <= '0;
      s_out    <= 1'b0;
      r_out    <= 1'b0;
      e_out    <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
      drop     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // A conflicting pair only ever reports conflict, even while busy.
      conflict <= pair_req;
      drop     <= single_req && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (single_req) begin
            tgt   <= set_req;
            s_out <= set_req;
            r_out <= reset_req;
            e_out <= 1'b0;
            busy  <= 1'b1;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          e_out  <= 1'b1;
          en_cnt <= '0;
          state  <= ST_ENABLE;
        end
        ST_ENABLE: begin
          if (en_cnt == EN_LAST) begin
            e_out <= 1'b0;
            state <= ST_HOLD;
          end else begin
            en_cnt <= en_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          // Gate already closed; releasing data one clock later keeps
          // S/R stable past the falling edge of E.
          s_out <= 1'b0;
          r_out <= 1'b0;
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (latch_q != tgt) err <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          s_out <= 1'b0;
          r_out <= 1'b0;
          e_out <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs_drive_ctrl.sv
module tb_rs_drive_ctrl;

  localparam int DEB = 4;
  localparam int EN  = 2;
  localparam int W   = 20;  // {err_after, tgt, kind[1:0], cycle[15:0]}

  localparam logic [1:0] K_SEQ  = 2'd0;
  localparam logic [1:0] K_CONF = 2'd1;
  localparam logic [1:0] K_DROP = 2'd2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       set_btn = 1'b0;
  logic       reset_btn = 1'b0;
  logic       latch_q;
  logic       s_out, r_out, e_out, busy, conflict, drop, err;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  rs_drive_ctrl #(.DEB_CYCLES(DEB), .EN_CYCLES(EN)) dut (
    .clk       (clk),
    .rst       (rst),
    .set_btn   (set_btn),
    .reset_btn (reset_btn),
    .latch_q   (latch_q),
    .s_out     (s_out),
    .r_out     (r_out),
    .e_out     (e_out),
    .busy      (busy),
    .conflict  (conflict),
    .drop      (drop),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // Gated RS latch environment; stuck forces Q to 0.
  logic latch_st = 1'b0;
  logic stuck = 1'b0;
  always @(posedge clk) begin
    if (e_out) begin
      if (s_out) latch_st <= 1'b1;
      else if (r_out) latch_st <= 1'b0;
    end
  end
  assign latch_q = stuck ? 1'b0 : latch_st;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on whole-cycle events: raw samples reach the debouncer two
  // clocks late, a level change needs DEB differing samples, a rising
  // change is a request, and the controller acts on it one clock later.
  int   m_cyc = 0;
  logic hs[$];
  logic hr[$];
  logic deb_s, deb_r, rq_s, rq_r, m_err;
  int   run_s, run_r;
  int   seq_start = -1000;

  task automatic deb_step(input logic x, inout logic deb, inout int run, output logic rq);
    rq = 1'b0;
    if (x != deb) begin
      run++;
      if (run == DEB) begin
        deb = x;
        run = 0;
        rq  = x;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic push_tok(input logic e, input logic t, input logic [1:0] k);
    exp_q.push_back({e, t, k, m_cyc[15:0]});
  endtask

  task automatic model_step(input logic vs, input logic vr, input logic vrst);
    logic xs, xr, busy_m, q_at_check, ns, nr;
    m_cyc++;
    if (vrst) begin
      hs.delete(); hr.delete();
      deb_s = 0; deb_r = 0; run_s = 0; run_r = 0;
      rq_s = 0; rq_r = 0; m_err = 0; seq_start = -1000;
      return;
    end
    busy_m = (m_cyc >= seq_start + 1) && (m_cyc <= seq_start + EN + 3);
    if (rq_s && rq_r) begin
      push_tok(m_err, 1'b0, K_CONF);
    end else if (rq_s || rq_r) begin
      if (busy_m) begin
        push_tok(m_err, 1'b0, K_DROP);
      end else begin
        seq_start  = m_cyc;
        q_at_check = stuck ? 1'b0 : rq_s;
        if (q_at_check != rq_s) m_err = 1'b1;
        push_tok(m_err, rq_s, K_SEQ);
      end
    end
    hs.push_back(vs); hr.push_back(vr);
    if (hs.size() > 3) void'(hs.pop_front());
    if (hr.size() > 3) void'(hr.pop_front());
    xs = (hs.size() == 3) ? hs[0] : 1'b0;
    xr = (hr.size() == 3) ? hr[0] : 1'b0;
    deb_step(xs, deb_s, run_s, ns);
    deb_step(xr, deb_r, run_r, nr);
    rq_s = ns;
    rq_r = nr;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic vs, input logic vr, input logic vrst);
    #1;
    set_btn = vs; reset_btn = vr; rst = vrst;
    @(posedge clk);
    model_step(vs, vr, vrst);
  endtask

  task automatic hold(input logic vs, input logic vr, input int n);
    for (int i = 0; i < n; i++) step(vs, vr, 1'b0);
  endtask

  // ---------------- monitor ----------------
  int           n_cyc = 0;
  logic         rst_s = 1'b0;
  logic         busy_prev = 1'b0;
  logic         in_seq = 1'b0;
  int           ph = 0;
  logic         t_tgt = 1'b0;
  logic         t_err = 1'b0;
  logic [W-1:0] tok;

  always @(posedge clk) rst_s <= rst;

  task automatic pop_expect(input logic [1:0] kind);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL spurious_event kind=%0d cycle=%0d required=none", kind, n_cyc);
    end else begin
      tok = exp_q.pop_front();
      check("event_kind", 32'(tok[17:16]), 32'(kind));
      check("event_cycle", 32'(tok[15:0]), 32'(n_cyc[15:0]));
    end
  endtask

  task automatic seq_phase_check();
    logic [3:0] e;
    if (ph == 0)           e = {t_tgt, ~t_tgt, 1'b0, 1'b1};
    else if (ph <= EN)     e = {t_tgt, ~t_tgt, 1'b1, 1'b1};
    else if (ph == EN + 1) e = {t_tgt, ~t_tgt, 1'b0, 1'b1};
    else if (ph == EN + 2) e = 4'b0001;
    else                   e = 4'b0000;
    check("seq_srebusy", 32'({s_out, r_out, e_out, busy}), 32'(e));
    if (ph == EN + 3) begin
      check("err_after_check", 32'(err), 32'(t_err));
      in_seq = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      n_cyc++;
      check("s_r_exclusive", 32'(s_out & r_out), 32'd0);
      if (rst_s) begin
        check("reset_outputs", 32'({s_out, r_out, e_out, busy, conflict, drop, err, state_dbg}), 32'd0);
        in_seq = 1'b0;
      end else begin
        if (conflict) pop_expect(K_CONF);
        if (drop) pop_expect(K_DROP);
        if (in_seq) begin
          ph++;
          seq_phase_check();
        end else if (busy && !busy_prev) begin
          pop_expect(K_SEQ);
          t_tgt  = tok[18];
          t_err  = tok[19];
          in_seq = 1'b1;
          ph     = 0;
          seq_phase_check();
        end else begin
          check("idle_srebusy", 32'({s_out, r_out, e_out, busy}), 32'd0);
        end
      end
      busy_prev = busy;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic ts, tr, vs, vr;
    hold(1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);

    // clean set press
    hold(1'b1, 1'b0, 12);
    hold(1'b0, 1'b0, 20);

    // bouncing reset press: 1,0,1 then stable 1
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    hold(1'b0, 1'b1, 14);
    hold(1'b0, 1'b0, 20);

    // simultaneous press
    hold(1'b1, 1'b1, 12);
    hold(1'b0, 1'b0, 20);

    // reset request lands during ENABLE of a set sequence
    hold(1'b1, 1'b0, 2);
    hold(1'b1, 1'b1, 12);
    hold(1'b0, 1'b0, 20);

    // stuck latch: err raised, then survives a good reset sequence
    stuck = 1'b1;
    hold(1'b1, 1'b0, 12);
    hold(1'b0, 1'b0, 20);
    stuck = 1'b0;
    hold(1'b0, 1'b1, 12);
    hold(1'b0, 1'b0, 20);

    // rst during ENABLE, button kept high through reset release
    hold(1'b1, 1'b0, 9);
    step(1'b1, 1'b0, 1'b1);
    hold(1'b1, 1'b0, 14);
    hold(1'b0, 1'b0, 20);

    // randomized bouncing presses, occasional stuck latch and rst
    for (int it = 0; it < 12; it++) begin
      stuck = ($urandom_range(0, 3) == 0);
      ts = 1'b0;
      tr = 1'b0;
      for (int i = 0; i < $urandom_range(10, 40); i++) begin
        if ($urandom_range(0, 6) == 0) ts = ~ts;
        if ($urandom_range(0, 6) == 0) tr = ~tr;
        vs = ($urandom_range(0, 5) == 0) ? ~ts : ts;
        vr = ($urandom_range(0, 5) == 0) ? ~tr : tr;
        step(vs, vr, ($urandom_range(0, 60) == 0));
      end
      hold(1'b0, 1'b0, 25);
    end

    hold(1'b0, 1'b0, 20);
    #2;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("no_open_sequence", 32'(in_seq), 32'd0);
    check("final_err", 32'(err), 32'(m_err));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_drive_ctrl.md
RS_DRIVE_CTRL -- requirements
Module: rs_drive_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable samples required before a debounced button level changes; legal range 1..255.
REQ-002 Parameter EN_CYCLES, default 2: width in clocks of the E pulse; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 set_btn  input  1  raw, asynchronous, bouncing set push-button.
REQ-006 reset_btn  input  1  raw, asynchronous, bouncing reset push-button.
REQ-007 latch_q  input  1  readback of the gated RS latch Q output.
REQ-008 s_out  output  1  S drive to the gated RS latch.
REQ-009 r_out  output  1  R drive to the gated RS latch.
REQ-010 e_out  output  1  E (gate) drive to the gated RS latch.
REQ-011 busy  output  1  high while a write sequence is in progress (any state except IDLE).
REQ-012 conflict  output  1  one-cycle pulse when set and reset requests arrive in the same cycle.
REQ-013 drop  output  1  one-cycle pulse when a request arrives while busy is high.
REQ-014 err  output  1  sticky flag; set when the readback check fails.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer, then a debouncer: the debounced level takes the synchronized value only after DEB_CYCLES consecutive equal samples that differ from the current debounced level.
REQ-016 A request SHALL be a single-cycle pulse on a 0->1 edge of the debounced level; a 1->0 edge SHALL produce no request.
REQ-017 Set and reset requests in the same cycle SHALL be discarded, and conflict SHALL pulse in the following cycle; s_out and r_out SHALL never be 1 at the same time.
REQ-018 FSM states: IDLE, SETUP, ENABLE, HOLD, CHECK.
REQ-019 IDLE: outputs r/s/e=0; on a single valid request, store tgt (set=1, reset=0) and go to SETUP.
REQ-020 SETUP (1 clk): drive s_out=tgt and r_out=~tgt with e_out=0, so that data is stable before the gate opens; next state is ENABLE.
REQ-021 ENABLE (exactly EN_CYCLES clks): keep s/r, e_out=1; a 4-bit counter terminates the state; next state is HOLD.
REQ-022 HOLD (1 clk): e_out=0 with s/r still held, so that data outlasts the gate; next state is CHECK.
REQ-023 CHECK (1 clk): s/r=0, e_out=0; if latch_q != tgt, set err; next state is IDLE.
REQ-024 Total sequence length SHALL be EN_CYCLES+3 clocks from entry into SETUP to return to IDLE; busy SHALL be high for exactly those cycles.
REQ-025 Any request arriving while busy is high SHALL be discarded, not queued, and drop SHALL pulse in the next cycle; a conflicting pair arriving while busy SHALL raise conflict only.
REQ-026 err SHALL stay set until rst; later successful sequences SHALL NOT clear it.
REQ-027 All outputs SHALL be registered; no output SHALL depend combinationally on any input.

Reset
REQ-028 While rst=1: FSM=IDLE; s_out=r_out=e_out=busy=conflict=drop=err=0; synchronizers, debounced levels and counters are cleared to 0; tgt is cleared to 0.
REQ-029 rst asserted mid-sequence (any state) SHALL abort the sequence on the next edge without any further E pulse; latch contents are left as they are.
REQ-030 A button held high through reset release SHALL produce one request once it has been debounced (the debounced level starts at 0).

Structure
REQ-031 Shared package rs_drive_pkg SHALL hold the FSM state enum, the DEB_CYCLES/EN_CYCLES defaults, and the counter width constants.
REQ-032 Sub-module btn_debounce (synchronizer, debounce counter, rise pulse) SHALL be instantiated twice.

Verification
REQ-033 Clean set press, EN_CYCLES=2, latch model correct -> after 2+4 clks the request fires; SETUP s=1/r=0/e=0; e=1 for 2 clks; HOLD; CHECK; busy high for 5 clks; err=0.
REQ-034 Bouncing reset_btn (toggle every clk for 3 clks, then stable 1), DEB_CYCLES=4 -> exactly one request, r_out=1 sequence, no extra E pulses.
REQ-035 set_btn and reset_btn rise in the same clk -> conflict pulses once, s_out/r_out/e_out stay 0, busy=0.
REQ-036 Set press, then reset press debounced during ENABLE -> drop pulses once; only the set sequence runs; latch_q=1 at CHECK.
REQ-037 Latch model stuck at 0 plus a set request -> err=1 after CHECK, and err stays 1 through a later good reset sequence.
REQ-038 rst pulsed for 1 clk during ENABLE -> the next cycle shows IDLE with all outputs 0, and no further E=1 until a new request.
